ps2_key_event_rx: RTL and testbench
===================================

// Module: ps2_key_event_rx
// PURPOSE
//  PS/2 keyboard front end feeding the note/game logic. Samples PS2_CLK/PS2_DAT in the CLOCK_50 domain.
//  Deframes 11-bit device-to-host frames and folds E0/F0 prefixes into one key event per make/break.
//  Buffers events in a small show-ahead FIFO with a valid/ready handshake toward the consumer.
// PARAMETERS
//  CLK_HZ       50_000_000  system clock frequency; sets the timeout count
//  TIMEOUT_US   2000        max gap between PS2_CLK falling edges inside one frame
//  FIFO_DEPTH   4           event FIFO entries; power of two, >=2
// PORTS
//  CLOCK_50   in   1  system clock; all state on its rising edge
//  resetn     in   1  asynchronous, active-low reset (board KEY[0])
//  PS2_CLK    in   1  raw keyboard clock, asynchronous, idle high
//  PS2_DAT    in   1  raw keyboard data, asynchronous, idle high
//  ev_valid   out  1  FIFO head holds an event
//  ev_ready   in   1  consumer accepts the head event when ev_valid && ev_ready
//  ev_code    out  8  scan code of the head event
//  ev_ext     out  1  head event was E0-prefixed
//  ev_break   out  1  head event was F0-prefixed (key release)
//  frame_err  out  1  one-cycle pulse on a start, parity, stop or timeout error
//  overflow   out  1  sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async assert, sync release) clears the FSM to IDLE, empties the FIFO and clears the prefix flags.
//   All outputs read 0 during reset; synchroniser flops reset to 1.
//  Sync: each input passes through a 2-FF synchroniser. A falling edge (fe) is the registered synced
//   clock at 1 and the synced clock at 0. Data is sampled from the synced PS2_DAT in the fe cycle.
//  Frame FSM (acts only on fe, except timeout):
//   IDLE:   fe with dat=0 -> DATA, bit count 0. fe with dat=1 -> stay in IDLE and pulse frame_err.
//   DATA:   shift dat in LSB first; after the 8th bit -> PARITY.
//   PARITY: store the bit -> STOP.
//   STOP:   dat=1 and odd parity over the 9 bits -> byte_ok pulse; otherwise pulse frame_err.
//           Either way -> IDLE.
//  Timeout: in any state other than IDLE, a counter reloads on each fe.
//   Reaching CLK_HZ/1_000_000*TIMEOUT_US cycles without an fe -> IDLE and pulse frame_err.
//  Prefix decode on byte_ok:
//   0xE0 sets ext_f. 0xF0 sets brk_f. Neither produces an event.
//   Any other byte pushes {ext_f,brk_f,byte} into the FIFO and clears both flags.
//   frame_err clears both flags.
//  FIFO: 10-bit entries, show-ahead; ev_code, ev_ext and ev_break present the head combinationally from storage.
//   Latency: the byte_ok pulse is registered in cycle N (the stop-bit fe cycle); the push happens in
//    N+1; ev_valid is high in N+2 when the FIFO was empty.
//   Pop is ev_valid && ev_ready. ev_valid=0 ignores ev_ready.
//   Push while full: the event is dropped and overflow is set, sticky until reset.
//   Push and pop in the same cycle while full: both happen; no drop, no overflow.
//   Push and pop in the same cycle while empty: push only.
//   Read and write pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
//  Reset mid-frame abandons the partial frame; the next start bit is decoded normally.
//  frame_err and byte_ok are never high in the same cycle.
// TESTING
//  1 Frame 0x1C (bits 0,00111000,0,1 with odd parity=0), ev_ready=1 -> one event: code=1C, ext=0, break=0.
//    ev_valid is high for exactly 1 cycle.
//  2 Bytes F0,1C, then E0,F0,74 -> two events in order: {0,1,1C} then {1,1,74}.
//    No events are produced for the prefix bytes.
//  3 Frame 0x1C with the parity bit flipped, preceded by E0 -> frame_err pulses once and no event.
//    A following 0x1C gives ext=0.
//  4 Hold ev_ready=0 and send 5 make codes 15,1D,24,2D,2C -> overflow=1.
//    Raising ev_ready drains 15,1D,24,2D and then ev_valid=0.
//  5 Send 5 bits of a frame, then idle for 2.1 ms -> one frame_err and the FSM returns to IDLE.
//    A following 0x1C is decoded correctly.
//  6 Pull resetn low mid-frame with a non-empty FIFO -> ev_valid=0 and overflow=0.
//    After release, frame 0x5A yields code=5A.

Source files
------------

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes 11-bit frames,
// folds E0/F0 prefixes into one event per make/break and queues events in a show-ahead FIFO.
module ps2_key_event_rx #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned TmoCycles = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned TW        = $clog2(TmoCycles + 1);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic          clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
    logic          fe;
    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_ok_q, byte_ok_d;
    logic          err_d;
    logic          ext_f, brk_f;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full, pop, push_req, push;
    logic [9:0]    head;

    // Two-flop synchronisers plus a delayed copy of the clock for edge detection.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= PS2_CLK;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= PS2_DAT;
            dat_sync <= dat_meta;
        end
    end

    assign fe = clk_prev & ~clk_sync;

    // Frame FSM state and registered byte_ok / frame_err pulses.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            byte_ok_q <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            byte_ok_q <= byte_ok_d;
            frame_err <= err_d;
        end
    end

    // Frame FSM next state: advances on PS2_CLK falling edges, bails out on inter-bit timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        byte_ok_d = 1'b0;
        err_d     = 1'b0;
        if (state_q == StIdle) begin
            tmo_d = '0;
            if (fe) begin
                if (!dat_sync) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (fe) begin
            tmo_d = '0;
            unique case (state_q)
                StData: begin
                    shreg_d = {dat_sync, shreg_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                    else bit_cnt_d = bit_cnt_q + 3'd1;
                end
                StParity: begin
                    par_d   = dat_sync;
                    state_d = StStop;
                end
                default: begin
                    if (dat_sync && (^{par_q, shreg_q})) byte_ok_d = 1'b1;
                    else err_d = 1'b1;
                    state_d = StIdle;
                end
            endcase
        end else if (tmo_q == TW'(TmoCycles - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // Prefix flags: remembered until the next real code byte or any frame error.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (frame_err) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (byte_ok_q) begin
            if (shreg_q == 8'hE0) begin
                ext_f <= 1'b1;
            end else if (shreg_q == 8'hF0) begin
                brk_f <= 1'b1;
            end else begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
            end
        end
    end

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign ev_valid = ~empty;
    assign pop      = ev_valid & ev_ready;
    assign push_req = byte_ok_q && (shreg_q != 8'hE0) && (shreg_q != 8'hF0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push     = push_req & (~full | pop);
    assign head     = mem[rptr[AW-1:0]];
    // Gated so the outputs read zero while empty and during reset.
    assign {ev_ext, ev_break, ev_code} = ev_valid ? head : 10'd0;

    // FIFO storage; no reset needed since reads are gated by ev_valid.
    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wptr[AW-1:0]] <= {ext_f, brk_f, shreg_q};
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + (AW + 1)'(1);
            if (pop) rptr <= rptr + (AW + 1)'(1);
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Self-checking bench for ps2_key_event_rx: directed scenarios plus a random frame phase,
// checked against an event-level model of the keyboard protocol.
module tb_ps2_key_event_rx;

    localparam int unsigned CLK_HZ     = 1_000_000;
    localparam int unsigned TIMEOUT_US = 200;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned TMO        = CLK_HZ / 1_000_000 * TIMEOUT_US;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       ev_ready = 1'b0;
    logic       ev_valid, ev_ext, ev_break, frame_err, overflow;
    logic [7:0] ev_code;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_drain = 1'b1;
    int         m_occ = 0;
    int         exp_err = 0;
    int         err_seen = 0;
    int         run = 0;
    int         max_run = 0;
    logic       rnd_ready = 1'b0;

    ps2_key_event_rx #(
        .CLK_HZ    (CLK_HZ),
        .TIMEOUT_US(TIMEOUT_US),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_code  (ev_code),
        .ev_ext   (ev_ext),
        .ev_break (ev_break),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Observe consumed events, error pulses and ev_valid run lengths away from the active edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (ev_valid && ev_ready) got_q.push_back({ev_ext, ev_break, ev_code});
            if (frame_err) err_seen++;
            if (ev_valid) run++;
            else run = 0;
            if (run > max_run) max_run = run;
        end
    end

    // Random consumer back-pressure during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) ev_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        ev_ready = v;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b1;
        wait_cyc(10);
    endtask

    // Protocol-level model of one received frame.
    function automatic void model_frame(input logic [7:0] b, input logic ok);
        if (!ok) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (m_drain || m_occ < DEPTH) begin
                exp_q.push_back({m_ext, m_brk, b});
                if (!m_drain) m_occ++;
            end else begin
                m_ovf = 1'b1;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        wait_cyc(20);
        model_frame(b, ~bad_par);
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk({tag, "_event"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        chk({tag, "_err"}, 32'(err_seen), 32'(exp_err));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int         kind;

        // Reset state
        wait_cyc(3);
        @(negedge clk);
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_code", 32'({ev_ext, ev_break, ev_code}), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        wait_cyc(5);

        // 1: single make code, ev_valid lasts one cycle with ready held high
        set_ready(1'b1);
        max_run = 0;
        send_frame(8'h1C, 1'b0);
        wait_cyc(20);
        chk("t1_run", 32'(max_run), 32'd1);
        check_events("t1");

        // 2: break and extended break
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h74, 1'b0);
        wait_cyc(20);
        check_events("t2");

        // 3: parity error clears a pending E0
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b1);
        send_frame(8'h1C, 1'b0);
        wait_cyc(20);
        check_events("t3");

        // 4: overflow with consumer stalled, then drain
        set_ready(1'b0);
        m_drain = 1'b0;
        m_occ = 0;
        send_frame(8'h15, 1'b0);
        send_frame(8'h1D, 1'b0);
        send_frame(8'h24, 1'b0);
        send_frame(8'h2D, 1'b0);
        send_frame(8'h2C, 1'b0);
        wait_cyc(5);
        @(negedge clk);
        chk("t4_ovf_full", 32'(overflow), 32'(m_ovf));
        chk("t4_valid_full", 32'(ev_valid), 32'd1);
        set_ready(1'b1);
        wait_cyc(20);
        @(negedge clk);
        chk("t4_valid_drained", 32'(ev_valid), 32'd0);
        m_drain = 1'b1;
        m_occ = 0;
        check_events("t4");

        // 5: partial frame times out; prefix before it is discarded
        send_frame(8'hE0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_dat = 1'b1;
        wait_cyc(TMO + 60);
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        chk("t5_timeout_err", 32'(err_seen), 32'(exp_err));
        send_frame(8'h1C, 1'b0);
        wait_cyc(20);
        check_events("t5");

        // Random phase: mixed prefixes, codes and parity errors under random back-pressure
        rnd_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            kind = int'($urandom_range(0, 5));
            b = 8'($urandom_range(1, 8'hDF));
            if (kind == 0) send_frame(8'hE0, 1'b0);
            else if (kind == 1) send_frame(8'hF0, 1'b0);
            else if (kind == 2) send_frame(b, 1'b1);
            else send_frame(b, 1'b0);
        end
        wait_cyc(100);
        rnd_ready = 1'b0;
        wait_cyc(2);
        check_events("rand");

        // 6: reset mid-frame with a non-empty, overflowed FIFO
        set_ready(1'b0);
        m_drain = 1'b0;
        m_occ = 0;
        for (int i = 0; i < 5; i++) send_frame(8'h30 + 8'(i), 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_dat = 1'b1;
        @(negedge clk);
        chk("t6_ovf_before", 32'(overflow), 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        chk("t6_rst_valid", 32'(ev_valid), 32'd0);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
        chk("t6_rst_err", 32'(frame_err), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_q.delete();
        got_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        m_occ = 0;
        m_drain = 1'b1;
        set_ready(1'b1);
        send_frame(8'h5A, 1'b0);
        wait_cyc(20);
        check_events("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
